// File: rtl/light_tx_scheduler.sv
// light_tx_scheduler
//   Shares one LightIO packet transmitter among NUM_REQ requesters.
//   Winner choice: priority class first, then round-robin within the class
//   starting after the last winner. The winner's packet is latched onto
//   tx_data, tx_enable pulses for one cycle, and the grant is held until
//   irq_tx (ignored while tx_enable is high) or until TX_TIMEOUT expires.
//
//   Optional feature macro: SCHED_AGING_EN
//     defined   -> per-requester saturating wait counters; a requester that
//                  has waited MAX_WAIT cycles joins the priority class.
//     undefined -> strict class priority (normal requesters may starve).
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_REQ]      level request per requester
//   prio        in   [NUM_REQ]      requester i is in the priority class
//   data_in     in   [NUM_REQ*PW]   packet i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   irq_tx      in   transmitter finished (one-cycle pulse)
//   grant       out  [NUM_REQ]      one-hot owner, zero when idle
//   done        out  [NUM_REQ]      one-cycle completion pulse to the owner
//   tx_enable   out  one-cycle start pulse to the transmitter
//   tx_data     out  [PACKET_WIDTH] latched packet, held when idle
//   tx_timeout  out  one-cycle pulse when a transfer is aborted

`ifdef SCHED_AGING_EN
// Per-requester wait counter. Counts cycles spent requesting without the
// grant, saturates at MAX_WAIT, and flags starvation while saturated.
module light_tx_wait_ctr #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic granted,
  output logic starved
);
  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)                cnt <= '0;
    else if (!req || granted) cnt <= '0;
    else if (cnt != W'(MAX_WAIT)) cnt <= cnt + 1'b1;
  end

  assign starved = (cnt == W'(MAX_WAIT));
endmodule
`endif

module light_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int PACKET_WIDTH = 8,
  parameter int MAX_WAIT     = 15,
  parameter int TX_TIMEOUT   = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              prio,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] data_in,
  input  logic                            irq_tx,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            tx_enable,
  output logic [PACKET_WIDTH-1:0]         tx_data,
  output logic                            tx_timeout
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_WAIT < 1 || TX_TIMEOUT < 2) begin : g_bad_cfg
    $error("light_tx_scheduler: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [TMR_W-1:0]   timer;

  logic [NUM_REQ-1:0] eff;    // effective priority class membership
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick;   // one-hot winner taken at this edge, else 0
  logic [IDX_W-1:0]   win;
  logic               found;

`ifdef SCHED_AGING_EN
  logic [NUM_REQ-1:0] starved;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait
    light_tx_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clock   (clock),
      .reset   (reset),
      .req     (req[i]),
      .granted (grant[i] | pick[i]),
      .starved (starved[i])
    );
  end

  assign eff = prio | starved;
`else
  assign eff = prio;
`endif

  // Class filter falls back to all requesters when nobody in the class asks;
  // the scan starts one past the last winner so the last winner comes last.
  always_comb begin
    int idx;
    idx   = 0;
    cand  = req & eff;
    if (cand == '0) cand = req;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  assign pick = (state == S_IDLE && found) ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      done       <= '0;
      tx_enable  <= 1'b0;
      tx_data    <= '0;
      tx_timeout <= 1'b0;
      last       <= IDX_W'(NUM_REQ - 1);
      timer      <= '0;
    end else begin
      done       <= '0;
      tx_enable  <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= pick;
            tx_data   <= data_in[win*PACKET_WIDTH +: PACKET_WIDTH];
            tx_enable <= 1'b1;
            last      <= win;
            timer     <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          // An irq_tx coinciding with the start pulse belongs to no transfer
          // of ours, so it is dropped.
          if (irq_tx && !tx_enable) begin
            done  <= grant;
            grant <= '0;
            state <= S_IDLE;
          end else if (timer == TMR_W'(TX_TIMEOUT)) begin
            tx_timeout <= 1'b1;
            grant      <= '0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_light_tx_scheduler.sv
module tb_light_tx_scheduler;
  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MAXW = 15;
  localparam int TXTO = 255;
`ifdef SCHED_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, prio;
  logic [N*PW-1:0] data_in;
  logic            irq_tx;
  logic [N-1:0]    grant, done;
  logic            tx_enable, tx_timeout;
  logic [PW-1:0]   tx_data;

  light_tx_scheduler #(.NUM_REQ(N), .PACKET_WIDTH(PW), .MAX_WAIT(MAXW), .TX_TIMEOUT(TXTO)) dut (
    .clock(clock), .reset(reset), .req(req), .prio(prio), .data_in(data_in),
    .irq_tx(irq_tx), .grant(grant), .done(done), .tx_enable(tx_enable),
    .tx_data(tx_data), .tx_timeout(tx_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, transfer age and per-requester waiting times
  // as plain integers, advanced once per clock from the rules of operation.
  bit          m_busy = 0, m_en = 0, m_to = 0;
  int          m_owner = 0, m_last = N-1, m_timer = 0;
  int          m_wait[N];
  logic [N-1:0] m_grant = '0, m_done = '0;
  logic [PW-1:0] m_txd = '0;

  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] pr,
                            input logic [N*PW-1:0] d, input bit ir);
    logic [N-1:0] old_grant, pool;
    bit en_old;
    int w;
    w = -1;
    old_grant = m_grant;
    en_old = m_en;
    if (r) begin
      m_busy = 0; m_en = 0; m_to = 0; m_owner = 0; m_last = N-1; m_timer = 0;
      m_grant = '0; m_done = '0; m_txd = '0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    m_en = 0; m_done = '0; m_to = 0;
    if (!m_busy) begin
      if (rq != '0) begin
        pool = '0;
        for (int i = 0; i < N; i++)
          if (rq[i] && (pr[i] || (AGING && m_wait[i] == MAXW))) pool[i] = 1'b1;
        if (pool == '0) pool = rq;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (w < 0 && pool[c]) w = c;
        end
        m_busy = 1; m_owner = w; m_grant = N'(1 << w); m_txd = d[w*PW +: PW];
        m_en = 1; m_last = w; m_timer = 0;
      end
    end else begin
      if (ir && !en_old) begin
        m_done = N'(1 << m_owner); m_grant = '0; m_busy = 0;
      end else if (m_timer == TXTO) begin
        m_to = 1; m_grant = '0; m_busy = 0;
      end else m_timer++;
    end
    for (int i = 0; i < N; i++)
      if (!rq[i] || old_grant[i] || w == i) m_wait[i] = 0;
      else if (m_wait[i] < MAXW) m_wait[i]++;
  endtask

  // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge.
  task automatic cyc(input bit r, input logic [N-1:0] rq, input logic [N-1:0] pr,
                     input logic [N*PW-1:0] d, input bit ir);
    reset = r; req = rq; prio = pr; data_in = d; irq_tx = ir;
    model_step(r, rq, pr, d, ir);
    @(posedge clock); #1;
    chk("grant", 32'(grant), 32'(m_grant));
    chk("done", 32'(done), 32'(m_done));
    chk("tx_enable", 32'(tx_enable), 32'(m_en));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("tx_timeout", 32'(tx_timeout), 32'(m_to));
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    prio;
    logic [N*PW-1:0] data;
    logic            irq;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            en;
    logic [PW-1:0]   txd;
    logic            to;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int cnt0, cnt1, tdelay;
    bit saw_done;
    logic [N-1:0] exp_oh;
    logic [N*PW-1:0] rr_data;

    // Basic transfer, irq during tx_enable, irq while idle.
    tbl[0]  = '{4'b0001, 4'b0000, 32'h000000A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'hA5, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0000, 32'h000000A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA5, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0000, 32'h000000A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0000, 32'h000000A5, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 32'h000000A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 32'h000000A5, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    tbl[6]  = '{4'b0010, 4'b0000, 32'h00003C00, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'h3C, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, 32'h00003C00, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h3C, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, 32'h00003C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h3C, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0000, 32'h00003C00, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'h3C, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 32'h00003C00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h3C, 1'b0};

    reset = 1'b1; req = '0; prio = '0; data_in = '0; irq_tx = 1'b0;

    // Reset state
    cyc(1, '0, '0, '0, 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(tx_enable), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_to", 32'(tx_timeout), 0);

    for (int i = 0; i < 11; i++) begin
      cyc(0, tbl[i].req, tbl[i].prio, tbl[i].data, tbl[i].irq);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_en", i), 32'(tx_enable), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_txd", i), 32'(tx_data), 32'(tbl[i].txd));
      chk($sformatf("tbl%0d_to", i), 32'(tx_timeout), 32'(tbl[i].to));
    end

    // Round-robin over four equal requesters, first winner is requester 0.
    cyc(1, '0, '0, '0, 0);
    rr_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      exp_oh = N'(1 << (k % N));
      cyc(0, 4'b1111, 4'b0000, rr_data, 0);
      chk("rr_grant", 32'(grant), 32'(exp_oh));
      chk("rr_txd", 32'(tx_data), 32'(8'h11 * ((k % N) + 1)));
      cyc(0, 4'b1111, 4'b0000, rr_data, 0);
      cyc(0, 4'b1111, 4'b0000, rr_data, 1);
      chk("rr_done", 32'(done), 32'(exp_oh));
      chk("rr_gap", 32'(grant), 0);
    end

    // Class priority vs. aging: requester 1 is priority, 0 is normal.
    cyc(1, '0, '0, '0, 0);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(0, 4'b0011, 4'b0010, 32'h0000BBAA, m_busy && !m_en);
      if (done[0]) cnt0++;
      if (done[1]) cnt1++;
    end
    chk("prio_req1_served", 32'(cnt1 > 0), 1);
    chk("aging_req0_served", 32'(cnt0 > 0), 32'(AGING));

    // Timeout on requester 2 while requester 3 also waits.
    cyc(1, '0, '0, '0, 0);
    cyc(0, 4'b0100, 4'b0000, 32'h00770000, 0);
    chk("to_grant", 32'(grant), 32'h4);
    tdelay = 0; saw_done = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc(0, 4'b1100, 4'b0000, $urandom, 0);
      if (done != '0) saw_done = 1;
      if (tx_timeout) begin
        tdelay = n;
        chk("to_grant_clear", 32'(grant), 0);
        break;
      end
    end
    chk("to_delay", tdelay, TXTO + 1);
    chk("to_no_done", 32'(saw_done), 0);
    cyc(0, 4'b1100, 4'b0000, 32'h00000000, 0);
    chk("to_next_grant", 32'(grant), 32'h8);

    // Reset in the middle of a transfer.
    cyc(0, 4'b1111, 4'b0000, 32'h12345678, 0);
    cyc(0, 4'b1111, 4'b0000, 32'h12345678, 0);
    cyc(1, 4'b1111, 4'b0000, 32'h12345678, 1);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_txd", 32'(tx_data), 0);
    cyc(0, 4'b1111, 4'b0000, 32'h12345678, 0);
    chk("mid_rst_first", 32'(grant), 32'h1);
    chk("mid_rst_txd2", 32'(tx_data), 32'h78);

    // Random traffic against the model; second phase makes timeouts likely.
    for (int k = 0; k < 5000; k++)
      cyc(($urandom_range(499) == 0), N'($urandom), N'($urandom), $urandom,
          ($urandom_range(3) == 0));
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(999) == 0), N'($urandom), N'($urandom), $urandom,
          ($urandom_range(299) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/light_tx_scheduler.md
# light_tx_scheduler

Shares the single LightIO packet transmitter among NUM_REQ requesters. Requesters raise `req` with a packet on their `data_in` slice. The scheduler picks one winner: priority class first, then round-robin within the class. It latches the winner's packet and pulses `tx_enable` to the transmitter. It then holds the grant until the transmitter's `irq_tx` or a timeout. It sits between the protocol/command logic and the transmitter, replacing the two-input priority/normal arbitration with N-way fair sharing.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PACKET_WIDTH`, 8: packet width in bits.
- `MAX_WAIT`, 15: aging threshold in cycles, ≥1 (see Configuration).
- `TX_TIMEOUT`, 255: maximum cycles to wait for `irq_tx`, ≥2.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  request per requester, level.
- `prio`  in  NUM_REQ  requester i belongs to the priority class when high.
- `data_in`  in  NUM_REQ*PACKET_WIDTH  packet of requester i at bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- `irq_tx`  in  1  transmitter finished the packet; one-cycle pulse.
- `grant`  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- `done`  out  NUM_REQ  one-cycle pulse to the owner when its packet completes.
- `tx_enable`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  PACKET_WIDTH  latched packet; stable for the whole transfer.
- `tx_timeout`  out  1  one-cycle pulse when a transfer is aborted by timeout.

## Operation
- States:
  - IDLE: no owner.
  - SEND: transfer in flight.
- IDLE with any `req` high selects winner w:
  - Candidate set = requesters with `req` high and effective priority high. If that set is empty, candidate set = all requesters with `req` high.
  - w = first candidate in order last+1, last+2, … mod NUM_REQ.
  - At the clock edge: `grant`<=onehot(w), `tx_data`<=slice w, `tx_enable`<=1, last<=w, timer<=0, state<=SEND.
- SEND:
  - `tx_enable` returns to 0 after one cycle.
  - The timer increments every cycle.
  - `irq_tx` is accepted only while `tx_enable`=0.
  - On accepted `irq_tx`: `done[w]`<=1, `grant`<=0, state<=IDLE.
  - If the timer reaches TX_TIMEOUT before `irq_tx`: `tx_timeout`<=1, `grant`<=0, no `done`, state<=IDLE.
- Dropping `req` during SEND does not abort the transfer. `grant` and `done` still complete normally.
- `irq_tx` in IDLE is ignored.
- `req` and `prio` changes take effect only at the next IDLE decision.
- `tx_data` holds its last value when idle.

## Timing
- Reset values:
  - Outputs: `grant`=0, `done`=0, `tx_enable`=0, `tx_data`=0, `tx_timeout`=0.
  - Internal: state=IDLE, last=NUM_REQ-1 (requester 0 wins the first tie), timer=0, all wait counters=0.
- Latency: `req` high in IDLE at edge k gives `grant` and `tx_enable` high after edge k.
- `irq_tx` sampled at edge j gives `done` high after edge j, for one cycle. `grant` is low in the same cycle.
- Back-to-back: the cycle after `done` is IDLE. The next `grant` appears one cycle later, so there is a minimum of one idle cycle between grants.
- A requester that keeps `req` high after `done` becomes lowest round-robin priority.
- Timeout: `tx_timeout` pulses TX_TIMEOUT+1 cycles after `tx_enable` if no `irq_tx` arrives.
- Reset mid-SEND: all outputs clear on the next edge. No `done` or `tx_timeout` pulse is produced.

## Configuration
- `SCHED_AGING_EN` defined:
  - Each requester has a saturating wait counter (width ceil(log2(MAX_WAIT+1))).
  - The counter increments each cycle `req[i]`=1 and `grant[i]`=0.
  - The counter clears when `req[i]`=0 or when i is granted.
  - Effective priority = `prio[i]` OR (counter==MAX_WAIT), so starved normal requesters join the priority class.
- Undefined:
  - No counters.
  - Effective priority = `prio[i]` (strict class priority; normal requesters can starve).

## Test plan
- Reset, then `req`=0001, `data_in` slice0=8'hA5 → `grant`=0001, `tx_enable` pulse, `tx_data`=A5. `irq_tx` 3 cycles later → `done`=0001 for one cycle, `grant`=0.
- `req`=1111 held, `prio`=0, `irq_tx` after each start → grants in order 0001,0010,0100,1000,0001, each separated by one idle cycle.
- `req`=0011, `prio`=0010 → requester 1 is granted repeatedly. With `SCHED_AGING_EN`, requester 0 is granted once its counter reaches 15. Without the macro, requester 0 is never granted.
- Grant to requester 2, withhold `irq_tx` → `tx_timeout` pulse 256 cycles after `tx_enable`, `grant`=0, no `done`. The next grant goes to requester 3 if it is requesting.
- `irq_tx` in the same cycle `tx_enable`=1 and in IDLE → both ignored; the transfer completes only on a later `irq_tx`.
- Assert `reset` during SEND → the next cycle has all outputs 0 and no `done`. After release, `req`=1111 → requester 0 is granted first.
